// File: rtl/mem_port_arbiter_if.sv
// Request/grant bundle for the loader, data unit and fetch requesters plus the
// memory-array side of the shared single-port memory.
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 26
);
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_lock;
   logic          ld_gnt;

   logic          dt_req;
   logic          dt_we;
   logic [AW-1:0] dt_addr;
   logic [DW-1:0] dt_wdata;
   logic          dt_gnt;
   logic          dt_rvalid;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;

   logic [DW-1:0] rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    owner;

   // Arbiter side.
   modport slave (
      input  ld_req, ld_addr, ld_wdata, ld_lock,
      input  dt_req, dt_we, dt_addr, dt_wdata,
      input  if_req, if_addr, mem_rdata,
      output ld_gnt, dt_gnt, dt_rvalid, if_gnt, if_rvalid,
      output rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
   );

   // Requester / memory side.
   modport master (
      output ld_req, ld_addr, ld_wdata, ld_lock,
      output dt_req, dt_we, dt_addr, dt_wdata,
      output if_req, if_addr, mem_rdata,
      input  ld_gnt, dt_gnt, dt_rvalid, if_gnt, if_rvalid,
      input  rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (loader > data > fetch) for the shared program/data memory,
// with a fetch starvation guard, a loader lock and a one-cycle read-return tag.
module mem_port_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 26,
   parameter int STARVE_MAX = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus_if
);

   typedef enum logic {
      ST_RUN,
      ST_LOCKED
   } state_e;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_FETCH,
      RD_DATA
   } rd_owner_e;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_e     state_q, state_d;
   logic [2:0] starve_cnt_q, starve_cnt_d;
   rd_owner_e  rd_owner_q, rd_owner_d;

   logic ld_gnt, dt_gnt, if_gnt;

   // Grants depend only on the requests and registered state, and collapse while in reset.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no latch is inferred.
      ld_gnt = 1'b0;
      dt_gnt = 1'b0;
      if_gnt = 1'b0;
      if (rst_n) begin
         if (state_q == ST_LOCKED) begin
            ld_gnt = bus_if.ld_req;
         end else if (bus_if.ld_req) begin
            ld_gnt = 1'b1;
         end else if (bus_if.if_req && (starve_cnt_q == STARVE_LIM)) begin
            if_gnt = 1'b1;
         end else if (bus_if.dt_req) begin
            dt_gnt = 1'b1;
         end else if (bus_if.if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   assign bus_if.ld_gnt = ld_gnt;
   assign bus_if.dt_gnt = dt_gnt;
   assign bus_if.if_gnt = if_gnt;
   assign bus_if.mem_en = ld_gnt | dt_gnt | if_gnt;

   always_comb begin
      bus_if.mem_we    = 1'b0;
      bus_if.mem_addr  = '0;
      bus_if.mem_wdata = '0;
      bus_if.owner     = 2'b00;
      if (ld_gnt) begin
         bus_if.mem_we    = 1'b1;
         bus_if.mem_addr  = bus_if.ld_addr;
         bus_if.mem_wdata = bus_if.ld_wdata;
         bus_if.owner     = 2'b11;
      end else if (dt_gnt) begin
         bus_if.mem_we    = bus_if.dt_we;
         bus_if.mem_addr  = bus_if.dt_addr;
         bus_if.mem_wdata = bus_if.dt_wdata;
         bus_if.owner     = 2'b10;
      end else if (if_gnt) begin
         bus_if.mem_addr  = bus_if.if_addr;
         bus_if.owner     = 2'b01;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      rd_owner_d   = RD_NONE;

      if (if_gnt) begin
         rd_owner_d = RD_FETCH;
      end else if (dt_gnt && !bus_if.dt_we) begin
         rd_owner_d = RD_DATA;
      end

      if (state_q == ST_LOCKED) begin
         if (!bus_if.ld_lock) begin
            state_d = ST_RUN;
         end
      end else begin
         if (ld_gnt && bus_if.ld_lock) begin
            state_d = ST_LOCKED;
         end
         // A cycle without a fetch request ends the starvation window, even under a loader grant.
         if (!bus_if.if_req || if_gnt) begin
            starve_cnt_d = '0;
         end else if (dt_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         starve_cnt_q <= '0;
         rd_owner_q   <= RD_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign bus_if.if_rvalid = (rd_owner_q == RD_FETCH);
   assign bus_if.dt_rvalid = (rd_owner_q == RD_DATA);
   assign bus_if.rdata     = bus_if.mem_rdata;

endmodule
